// File: rtl/gen_sched_pkg.sv
// rtl/gen_sched_pkg.sv - shared scheduler types and round-robin search
package gen_sched_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, FINISH, ABORT} sched_state_t;

  localparam int MAX_REQ = 16;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Returns {any, id}: first set request after ptr, wrapping within n.
  function automatic logic [4:0] rr_search(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0] ptr, input int n);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 4'((int'(ptr) + k) % n);
      if (k <= n && !res[4] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: request vector + pointer -> one-hot grant and id
module rr_pick
  import gen_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    id,
  output logic             any
);

  logic [4:0]         res;
  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[N_REQ-1:0]  = req;
    res                 = rr_search(req_ext, 4'(ptr), N_REQ);
    any                 = res[4];
    id                  = IW'(res[3:0]);
    grant               = '0;
    if (res[4]) grant[id] = 1'b1;
  end

endmodule

// File: rtl/gen_rr_scheduler.sv
// rtl/gen_rr_scheduler.sv - round-robin sharing of one generator worker among N_REQ requesters
module gen_rr_scheduler
  import gen_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                        _clock,
  input  logic                        _reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*WIDTH-1:0]      req_base,
  input  logic [N_REQ*WIDTH-1:0]      req_limit,
  input  logic [N_REQ*WIDTH-1:0]      req_step,
  output logic [WIDTH-1:0]            gen_base,
  output logic [WIDTH-1:0]            gen_limit,
  output logic [WIDTH-1:0]            gen_step,
  output logic                        gen_start,
  output logic                        gen_reset,
  output logic                        gen_ready,
  input  logic                        gen_valid,
  input  logic [WIDTH-1:0]            gen_0,
  input  logic                        gen_done,
  input  logic                        _ready,
  output logic                        _valid,
  output logic [WIDTH-1:0]            _0,
  output logic [id_width(N_REQ)-1:0]  _id,
  output logic [N_REQ-1:0]            job_done,
  output logic [N_REQ-1:0]            job_error,
  output logic                        _busy
);

  localparam int IW  = id_width(N_REQ);
  localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  sched_state_t     state, state_nxt;
  logic [IW-1:0]    ptr, id_q, pick_id;
  logic [N_REQ-1:0] pick_grant, grant_q;
  logic             pick_any, load, wd_trip;
  logic [WDW-1:0]   wd, wd_nxt;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .id    (pick_id),
    .any   (pick_any)
  );

  assign gen_ready = (state == RUN) && (_ready || !_valid);
  assign load      = gen_valid && gen_ready;
  assign gen_start = (state == LAUNCH);
  assign gen_reset = (state == ABORT);
  assign req_ready = gen_start ? grant_q : '0;
  assign job_error = gen_reset ? grant_q : '0;
  assign _busy     = (state != IDLE);

  // The count is zeroed at grant, so the launch cycle is the first one counted.
  always_comb begin
    wd_nxt = wd;
    if (state == RUN && (gen_valid || gen_done)) wd_nxt = '0;
    else if (_valid && !_ready)                  wd_nxt = wd;
    else if (wd != WD_MAX)                       wd_nxt = wd + 1'b1;
  end

  assign wd_trip = (TIMEOUT != 0) && (wd_nxt == WD_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = RUN;
      RUN: begin
        if (gen_done && (!gen_valid || gen_ready)) state_nxt = FINISH;
        else if (wd_trip)                          state_nxt = ABORT;
      end
      FINISH:  if (!_valid) state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state     <= IDLE;
      ptr       <= IW'(N_REQ - 1);
      id_q      <= '0;
      grant_q   <= '0;
      gen_base  <= '0;
      gen_limit <= '0;
      gen_step  <= '0;
      wd        <= '0;
      _valid    <= 1'b0;
      _0        <= '0;
      _id       <= '0;
      job_done  <= '0;
    end else begin
      state    <= state_nxt;
      job_done <= '0;
      if (state == IDLE && pick_any) begin
        id_q      <= pick_id;
        grant_q   <= pick_grant;
        gen_base  <= req_base[pick_id*WIDTH +: WIDTH];
        gen_limit <= req_limit[pick_id*WIDTH +: WIDTH];
        gen_step  <= req_step[pick_id*WIDTH +: WIDTH];
        wd        <= '0;
      end else if (state == LAUNCH || state == RUN) begin
        wd <= wd_nxt;
      end
      if (state == LAUNCH) ptr <= id_q;
      if (state == FINISH && !_valid) job_done <= grant_q;
      // Output register drains in every state so an aborted job's last value still leaves.
      if (load) begin
        _valid <= 1'b1;
        _0     <= gen_0;
        _id    <= id_q;
      end else if (_ready) begin
        _valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gen_rr_scheduler.sv
// tb/tb_gen_rr_scheduler.sv - scoreboard bench for gen_rr_scheduler with a dup-yielding worker stub
module tb_gen_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  typedef struct {int id; logic [W-1:0] val;} exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready, job_done, job_error;
  logic [N*W-1:0] req_base = '0, req_limit = '0, req_step = '0;
  logic [W-1:0]   gen_base, gen_limit, gen_step, gen_0, out_data;
  logic           gen_start, gen_reset, gen_ready, gen_valid, gen_done;
  logic           out_ready = 1'b1, out_valid, busy;
  logic [1:0]     out_id;

  int   cyc = 0, n_checks = 0, n_pass = 0, rdy_mode = 0;
  int   launch_cyc = 0, done_lat = -1, abort_lat = -1, bp_viol = 0;
  exp_t exp_q[$];
  int   grant_q[$];
  int   ev_q[$];

  gen_rr_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    ._clock(clk), ._reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_limit(req_limit), .req_step(req_step),
    .gen_base(gen_base), .gen_limit(gen_limit), .gen_step(gen_step),
    .gen_start(gen_start), .gen_reset(gen_reset), .gen_ready(gen_ready),
    .gen_valid(gen_valid), .gen_0(gen_0), .gen_done(gen_done),
    ._ready(out_ready), ._valid(out_valid), ._0(out_data), ._id(out_id),
    .job_done(job_done), .job_error(job_error), ._busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Worker stub: each step yields its base value twice; done is combinational once the range ends.
  logic hang = 1'b0;
  logic w_active = 1'b0, w_done_r = 1'b1, w_phase = 1'b0, w_more;
  logic signed [W-1:0] w_cur = '0, w_limit = '0, w_step = '0;
  logic [W-1:0] w_base = '0;

  assign w_more    = w_cur < w_limit;
  assign gen_valid = w_active && !hang && w_more;
  assign gen_done  = w_done_r || (w_active && !hang && !w_more);
  assign gen_0     = w_base;

  always @(posedge clk) begin
    if (gen_reset) begin
      w_active <= 1'b0;
      w_done_r <= 1'b0;
    end else if (gen_start) begin
      w_active <= 1'b1;
      w_done_r <= 1'b0;
      w_phase  <= 1'b0;
      w_base   <= gen_base;
      w_cur    <= $signed(gen_base);
      w_limit  <= $signed(gen_limit);
      w_step   <= $signed(gen_step);
    end else if (w_active && !hang) begin
      if (!w_more) begin
        w_active <= 1'b0;
        w_done_r <= 1'b1;
      end else if (gen_ready) begin
        w_phase <= !w_phase;
        if (w_phase) w_cur <= w_cur + w_step;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected/timeout expected scoreboard match", name);
  endtask

  // Monitor: sampled 2 ns after the falling edge, after the drivers have settled.
  initial begin : monitor
    exp_t e;
    int   act;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (out_valid && !out_ready && gen_ready) bp_viol++;
        if (gen_start) launch_cyc = cyc;
        if (gen_reset) abort_lat = cyc - launch_cyc;
        if (req_ready != 0) begin
          if (grant_q.size() == 0) fail("grant_unexpected");
          else check("grant", req_ready, 1 << grant_q.pop_front());
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail("out_unexpected");
          else begin
            e = exp_q.pop_front();
            check("out_id", out_id, e.id);
            check("out_data", out_data, e.val);
          end
        end
        if (job_done != 0 || job_error != 0) begin
          act = int'(job_done) + 16 * int'(job_error);
          if (ev_q.size() == 0) fail("event_unexpected");
          else check("job_event", act, ev_q.pop_front());
          if (job_done != 0) done_lat = cyc - launch_cyc;
        end
      end
    end
  end

  task automatic set_job(input int i, input int b, input int l, input int s);
    req_base[i*W +: W]  = W'(b);
    req_limit[i*W +: W] = W'(l);
    req_step[i*W +: W]  = W'(s);
  endtask

  task automatic expect_job(input int i, input int b, input int l, input int s);
    exp_t e;
    grant_q.push_back(i);
    for (int v = b; v < l; v += s) begin
      e.id  = i;
      e.val = W'(b);
      exp_q.push_back(e);
      exp_q.push_back(e);
    end
    ev_q.push_back(1 << i);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((req_valid != 0 || busy || exp_q.size() != 0 || ev_q.size() != 0 ||
            grant_q.size() != 0) && k < budget) begin
      @(negedge clk);
      #1;
      req_valid = req_valid & ~req_ready;
      if (gen_reset) hang = 1'b0;
      k++;
    end
    if (k >= budget) fail(name);
  endtask

  task automatic do_reset();
    @(negedge clk); #1; rst_n = 1'b0;
    @(negedge clk); #1; rst_n = 1'b1;
  endtask

  initial begin : global_guard
    #600000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int k, g;
    repeat (3) @(negedge clk);
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_gen_start", gen_start, 0);
    check("rst_gen_reset", gen_reset, 0);
    check("rst_gen_ready", gen_ready, 0);
    check("rst_job_done", job_done, 0);
    check("rst_job_error", job_error, 0);
    @(negedge clk); #1; rst_n = 1'b1;

    // Single job
    set_job(0, 0, 10, 2);
    expect_job(0, 0, 10, 2);
    req_valid = 4'b0001;
    wait_drain("single_drain", 500);
    check("single_busy", busy, 0);

    // Contention from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_job(i, 0, 4, 2);
    for (int i = 0; i < N; i++) expect_job(i, 0, 4, 2);
    expect_job(0, 0, 4, 2);
    req_valid = 4'b1111;
    k = 0; g = 0;
    while (g < 5 && k < 2000) begin
      @(negedge clk); #1;
      if (req_ready != 0) g++;
      k++;
    end
    req_valid = '0;
    if (g < 5) fail("contention_grants");
    wait_drain("contention_drain", 2000);

    // Backpressure
    rdy_mode = 1;
    bp_viol  = 0;
    set_job(1, 0, 6, 1);
    expect_job(1, 0, 6, 1);
    req_valid = 4'b0010;
    wait_drain("bp_drain", 2000);
    rdy_mode = 0;
    check("bp_gen_ready_low", bp_viol, 0);

    // Empty job: the stale done during launch must not end it
    set_job(3, 5, 5, 1);
    expect_job(3, 5, 5, 1);
    req_valid = 4'b1000;
    wait_drain("empty_drain", 500);
    check("empty_done_latency", done_lat, 3);

    // Hung worker on requester 0, requester 1 follows
    hang = 1'b1;
    set_job(0, 0, 4, 1);
    set_job(1, 1, 3, 1);
    grant_q.push_back(0);
    ev_q.push_back(16);
    expect_job(1, 1, 3, 1);
    req_valid = 4'b0011;
    wait_drain("hang_drain", 1000);
    check("abort_latency", abort_lat, 16);

    // Asynchronous reset while a value is stuck on the output
    rdy_mode = 2;
    set_job(2, 9, 11, 1);
    grant_q.push_back(2);
    req_valid = 4'b0100;
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk); #1;
      req_valid = req_valid & ~req_ready;
      k++;
    end
    if (!out_valid) fail("midrun_valid_timeout");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_req_ready", req_ready, 0);
    check("arst_gen_start", gen_start, 0);
    check("arst_job_done", job_done, 0);
    check("arst_job_error", job_error, 0);
    exp_q.delete();
    grant_q.delete();
    ev_q.delete();
    req_valid = '0;
    rdy_mode  = 0;
    @(negedge clk); #1; rst_n = 1'b1;

    set_job(0, 9, 11, 1);
    set_job(3, -2, -1, 1);
    expect_job(0, 9, 11, 1);
    expect_job(3, -2, -1, 1);
    req_valid = 4'b1001;
    wait_drain("post_reset_drain", 1000);
    check("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
